// File: rtl/completion_arbiter_pkg.sv
// Shared types for the completion arbiter slice.
//   result_t  : 49-bit Result carried on every Message link
//   BURST_W   : width of fast-path burst counters (reusable by other arbiters)
//   burst_inc : saturating increment of a burst counter
package completion_arbiter_pkg;

    localparam int RESULT_W = 49;
    localparam int BURST_W  = 4;

    typedef logic [RESULT_W-1:0] result_t;

    function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] cnt,
                                                     input logic [BURST_W-1:0] lim);
        return (cnt >= lim) ? lim : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/completion_arbiter_if.sv
// Message link: a beat moves when en=1 and reject=0 in the same cycle.
//   en     : sender has a valid msg
//   msg    : Result payload (held by the sender while rejected)
//   reject : driven by the receiver, 1 = beat not taken
// Modports: sender (drives en/msg), receive (drives reject).
interface completion_arbiter_if;

    logic                           en;
    completion_arbiter_pkg::result_t msg;
    logic                           reject;

    modport sender  (output en, output msg, input  reject);
    modport receive (input  en, input  msg, output reject);

endinterface

// File: rtl/completion_arbiter_rr_picker.sv
// Round-robin picker (combinational).
//   rq    : request vector
//   start : index with highest priority this cycle
//   excl  : index that never wins here (fast-path requester)
//   idx   : chosen index, valid when none=0
//   none  : no eligible requester
// Rotate so start sits at bit 0, take the lowest set bit, rotate back.
module completion_arbiter_rr_picker #(
    parameter int N = 7,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] rq,
    input  logic [W-1:0] start,
    input  logic [W-1:0] excl,
    output logic [W-1:0] idx,
    output logic         none
);

    localparam logic [W:0] N_EXT = (W+1)'(N);

    logic [N-1:0] masked;
    logic [N-1:0] rot;
    logic [W:0]   pos;
    logic [W:0]   src;
    logic [W:0]   sum;

    always_comb begin
        masked       = rq;
        masked[excl] = 1'b0;

        rot = '0;
        for (int unsigned k = 0; k < N; k++) begin
            src = {1'b0, start} + (W+1)'(k);
            if (src >= N_EXT) src = src - N_EXT;
            rot[k] = masked[src[W-1:0]];
        end

        none = 1'b1;
        pos  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (rot[k] && none) begin
                none = 1'b0;
                pos  = (W+1)'(k);
            end
        end

        sum = {1'b0, start} + pos;
        if (sum >= N_EXT) sum = sum - N_EXT;
        idx = sum[W-1:0];
    end

endmodule

// File: rtl/completion_arbiter.sv
// Completion arbiter: grants one of NUM_REQ producers per cycle into a
// one-entry output slot feeding the completion stage. Round-robin among
// producers, with a bounded-burst fast path for PRIO_IDX.
//   clock         : system clock
//   reset_n       : synchronous active-low reset (overrides flash)
//   flash         : pipeline flush, drops the slot and blocks grants
//   req[]         : producer links (receive side, reject driven here)
//   complete_info : completion link (sender side, reject from consumer)
module completion_arbiter
    import completion_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 7,
    parameter int PRIO_IDX = 6,
    parameter int BURST    = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flash,
    completion_arbiter_if.receive req [NUM_REQ],
    completion_arbiter_if.sender  complete_info
);

    localparam int                 PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]   PRIO_P    = PTR_W'(PRIO_IDX);
    localparam logic [PTR_W-1:0]   LAST_P    = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0]   RR_FIRST  = (PRIO_IDX == 0) ? PTR_W'(1) : '0;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST);

    logic [NUM_REQ-1:0] rq;
    result_t            req_msg [NUM_REQ];

    logic               slot_valid;
    result_t            slot_data;
    logic [PTR_W-1:0]   rr_ptr;
    logic [BURST_W-1:0] burst_cnt;

    logic               free;
    logic               can_grant;
    logic               grant;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_none;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign rq[g]          = req[g].en;
        assign req_msg[g]     = req[g].msg;
        assign req[g].reject  = ~(grant & (sel == PTR_W'(g)));
    end

    completion_arbiter_rr_picker #(
        .N (NUM_REQ),
        .W (PTR_W)
    ) u_picker (
        .rq    (rq),
        .start (rr_ptr),
        .excl  (PRIO_P),
        .idx   (pick_idx),
        .none  (pick_none)
    );

    assign free      = ~slot_valid | ~complete_info.reject;
    assign can_grant = free & ~flash & reset_n;

    // Fast path first while under budget; once saturated it yields to
    // round-robin but still wins when nobody else is waiting (no bubble).
    always_comb begin
        grant = 1'b0;
        sel   = PRIO_P;
        if (rq[PRIO_IDX] && (burst_cnt < BURST_MAX)) begin
            grant = can_grant;
        end else if (!pick_none) begin
            grant = can_grant;
            sel   = pick_idx;
        end else if (rq[PRIO_IDX]) begin
            grant = can_grant;
        end
    end

    // Pointer advance skips the fast-path index so rr_ptr never rests on it.
    always_comb begin
        rr_next = (sel == LAST_P) ? '0 : sel + 1'b1;
        if (rr_next == PRIO_P) rr_next = (rr_next == LAST_P) ? '0 : rr_next + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
            rr_ptr     <= RR_FIRST;
            burst_cnt  <= '0;
        end else if (flash) begin
            slot_valid <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            if (!rq[PRIO_IDX]) burst_cnt <= '0;
            if (grant) begin
                slot_data  <= req_msg[sel];
                slot_valid <= 1'b1;
                if (sel == PRIO_P) begin
                    burst_cnt <= burst_inc(burst_cnt, BURST_MAX);
                end else begin
                    rr_ptr    <= rr_next;
                    burst_cnt <= '0;
                end
            end else if (free) begin
                slot_valid <= 1'b0;
            end
        end
    end

    assign complete_info.en  = slot_valid & ~flash & reset_n;
    assign complete_info.msg = reset_n ? slot_data : '0;

endmodule

// File: tb/tb_completion_arbiter.sv
module tb_completion_arbiter;
    import completion_arbiter_pkg::*;

    localparam int NR = 7;

    logic    clock = 1'b0;
    logic    reset_n = 1'b0;
    logic    flash = 1'b0;
    logic    cons_rej = 1'b0;
    logic    r_en  [NR];
    result_t r_msg [NR];
    logic    r_rej [NR];
    bit      cont  [NR];
    int      seq   [NR];

    int      checks = 0;
    int      errors = 0;
    result_t exp_q [$];
    result_t e;

    completion_arbiter_if req_if [NR] ();
    completion_arbiter_if cif ();

    for (genvar g = 0; g < NR; g++) begin : g_drv
        assign req_if[g].en  = r_en[g];
        assign req_if[g].msg = r_msg[g];
        assign r_rej[g]      = req_if[g].reject;
    end
    assign cif.reject = cons_rej;

    completion_arbiter #(
        .NUM_REQ  (7),
        .PRIO_IDX (6),
        .BURST    (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .flash         (flash),
        .req           (req_if),
        .complete_info (cif)
    );

    always #5 clock = ~clock;

    function automatic result_t make_msg(input int i, input int s);
        return {25'h0A5A5A5, i[7:0], s[15:0]};
    endfunction

    // One clock; producers whose beat was taken advance (continuous) or drop en.
    task automatic tick();
        bit acc [NR];
        for (int i = 0; i < NR; i++) acc[i] = r_en[i] && !r_rej[i];
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                if (cont[i]) begin
                    seq[i]++;
                    r_msg[i] = make_msg(i, seq[i]);
                end else begin
                    r_en[i] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic start_req(input int i);
        cont[i]  = 1'b1;
        seq[i]   = 0;
        r_en[i]  = 1'b1;
        r_msg[i] = make_msg(i, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) begin
            r_en[i] = 1'b0;
            cont[i] = 1'b0;
            r_msg[i] = '0;
        end
        cons_rej = 1'b0;
        flash = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start_req(2);
        start_req(6);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (cif.en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", cif.en); end
            checks++;
            if (cif.msg !== '0) begin errors++; $display("FAIL reset_msg got %h exp 0", cif.msg); end
            for (int j = 0; j < NR; j++) begin
                checks++;
                if (r_rej[j] !== 1'b1) begin errors++; $display("FAIL reset_rej[%0d] got %b exp 1", j, r_rej[j]); end
            end
            tick();
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        cont[2] = 1'b0;
        r_en[2] = 1'b1;
        r_msg[2] = 49'h1_2345;
        exp_q.push_back(49'h1_2345);
        #1;
        checks++;
        if (r_rej[2] !== 1'b0) begin errors++; $display("FAIL single_rej got %b exp 0", r_rej[2]); end
        tick();
        checks++;
        if (cif.en !== 1'b1) begin errors++; $display("FAIL single_en got %b exp 1", cif.en); end
        if (cif.en && !cons_rej) begin
            e = exp_q.pop_front();
            checks++;
            if (cif.msg !== e) begin errors++; $display("FAIL single_msg got %h exp %h", cif.msg, e); end
        end
        tick();
        checks++;
        if (cif.en !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", cif.en); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        int g  [7] = '{0, 1, 3, 0, 1, 3, -1};
        bit oe [7] = '{0, 1, 1, 1, 1, 1, 1};
        int cnt [NR] = '{default: 0};
        do_reset();
        start_req(0);
        start_req(1);
        start_req(3);
        for (int c = 0; c < 7; c++) begin
            if (g[c] >= 0) begin
                exp_q.push_back(make_msg(g[c], cnt[g[c]]));
                cnt[g[c]]++;
            end
        end
        for (int c = 0; c < 7; c++) begin
            if (c == 6) for (int j = 0; j < NR; j++) r_en[j] = 1'b0;
            #1;
            for (int j = 0; j < NR; j++) begin
                if (r_en[j]) begin
                    checks++;
                    if (r_rej[j] !== (g[c] != j))
                        begin errors++; $display("FAIL rr_rej c%0d[%0d] got %b exp %b", c, j, r_rej[j], g[c] != j); end
                end
            end
            checks++;
            if (cif.en !== oe[c]) begin errors++; $display("FAIL rr_en c%0d got %b exp %b", c, cif.en, oe[c]); end
            if (cif.en && !cons_rej) begin
                e = exp_q.pop_front();
                checks++;
                if (cif.msg !== e) begin errors++; $display("FAIL rr_msg c%0d got %h exp %h", c, cif.msg, e); end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rr_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_prio_burst();
        int g  [17] = '{6, 6, 6, 6, 0, 6, 6, 6, 6, 0, 6, 6, 6, 6, 6, 6, -1};
        int cnt [NR] = '{default: 0};
        do_reset();
        start_req(6);
        start_req(0);
        for (int c = 0; c < 17; c++) begin
            if (g[c] >= 0) begin
                exp_q.push_back(make_msg(g[c], cnt[g[c]]));
                cnt[g[c]]++;
            end
        end
        for (int c = 0; c < 17; c++) begin
            if (c == 10) r_en[0] = 1'b0;
            if (c == 16) r_en[6] = 1'b0;
            #1;
            for (int j = 0; j < NR; j++) begin
                if (r_en[j]) begin
                    checks++;
                    if (r_rej[j] !== (g[c] != j))
                        begin errors++; $display("FAIL prio_rej c%0d[%0d] got %b exp %b", c, j, r_rej[j], g[c] != j); end
                end
            end
            checks++;
            if (cif.en !== (c != 0)) begin errors++; $display("FAIL prio_en c%0d got %b exp %b", c, cif.en, c != 0); end
            if (cif.en && !cons_rej) begin
                e = exp_q.pop_front();
                checks++;
                if (cif.msg !== e) begin errors++; $display("FAIL prio_msg c%0d got %h exp %h", c, cif.msg, e); end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL prio_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reject_hold();
        do_reset();
        cont[2] = 1'b0;
        r_en[2] = 1'b1;
        r_msg[2] = 49'hAA;
        exp_q.push_back(49'hAA);
        #1;
        checks++;
        if (r_rej[2] !== 1'b0) begin errors++; $display("FAIL hold_first_rej got %b exp 0", r_rej[2]); end
        tick();
        cons_rej = 1'b1;
        start_req(4);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (cif.en !== 1'b1) begin errors++; $display("FAIL hold_en c%0d got %b exp 1", c, cif.en); end
            checks++;
            if (cif.msg !== 49'hAA) begin errors++; $display("FAIL hold_msg c%0d got %h exp %h", c, cif.msg, 49'hAA); end
            for (int j = 0; j < NR; j++) begin
                checks++;
                if (r_rej[j] !== 1'b1) begin errors++; $display("FAIL hold_rej c%0d[%0d] got %b exp 1", c, j, r_rej[j]); end
            end
            tick();
        end
        cons_rej = 1'b0;
        exp_q.push_back(make_msg(4, 0));
        #1;
        checks++;
        if (r_rej[4] !== 1'b0) begin errors++; $display("FAIL hold_refill_rej got %b exp 0", r_rej[4]); end
        if (cif.en && !cons_rej) begin
            e = exp_q.pop_front();
            checks++;
            if (cif.msg !== e) begin errors++; $display("FAIL hold_release_msg got %h exp %h", cif.msg, e); end
        end
        tick();
        r_en[4] = 1'b0;
        #1;
        checks++;
        if (cif.en !== 1'b1) begin errors++; $display("FAIL hold_next_en got %b exp 1", cif.en); end
        if (cif.en && !cons_rej) begin
            e = exp_q.pop_front();
            checks++;
            if (cif.msg !== e) begin errors++; $display("FAIL hold_next_msg got %h exp %h", cif.msg, e); end
        end
        tick();
        checks++;
        if (cif.en !== 1'b0) begin errors++; $display("FAIL hold_idle got %b exp 0", cif.en); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL hold_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_flash();
        int g  [7] = '{0, 1, -1, 3, 0, 1, -1};
        bit oe [7] = '{0, 1, 0, 0, 1, 1, 1};
        bit fl [7] = '{0, 0, 1, 0, 0, 0, 0};
        do_reset();
        start_req(0);
        start_req(1);
        start_req(3);
        // requester 1's first beat is granted then flushed before completing
        exp_q.push_back(make_msg(0, 0));
        exp_q.push_back(make_msg(3, 0));
        exp_q.push_back(make_msg(0, 1));
        exp_q.push_back(make_msg(1, 1));
        for (int c = 0; c < 7; c++) begin
            flash = fl[c];
            if (c == 6) for (int j = 0; j < NR; j++) r_en[j] = 1'b0;
            #1;
            for (int j = 0; j < NR; j++) begin
                if (r_en[j]) begin
                    checks++;
                    if (r_rej[j] !== (g[c] != j))
                        begin errors++; $display("FAIL flash_rej c%0d[%0d] got %b exp %b", c, j, r_rej[j], g[c] != j); end
                end
            end
            checks++;
            if (cif.en !== oe[c]) begin errors++; $display("FAIL flash_en c%0d got %b exp %b", c, cif.en, oe[c]); end
            if (cif.en && !cons_rej) begin
                e = exp_q.pop_front();
                checks++;
                if (cif.msg !== e) begin errors++; $display("FAIL flash_msg c%0d got %h exp %h", c, cif.msg, e); end
            end
            tick();
        end
        flash = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flash_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int g  [7] = '{0, 1, -1, -1, 0, 1, -1};
        bit oe [7] = '{0, 1, 0, 0, 0, 1, 1};
        bit rs [7] = '{1, 1, 0, 0, 1, 1, 1};
        do_reset();
        start_req(0);
        start_req(1);
        start_req(3);
        exp_q.push_back(make_msg(0, 0));
        exp_q.push_back(make_msg(0, 1));
        exp_q.push_back(make_msg(1, 1));
        for (int c = 0; c < 7; c++) begin
            reset_n = rs[c];
            if (c == 6) for (int j = 0; j < NR; j++) r_en[j] = 1'b0;
            #1;
            for (int j = 0; j < NR; j++) begin
                if (r_en[j]) begin
                    checks++;
                    if (r_rej[j] !== (g[c] != j))
                        begin errors++; $display("FAIL rstmid_rej c%0d[%0d] got %b exp %b", c, j, r_rej[j], g[c] != j); end
                end
            end
            checks++;
            if (cif.en !== oe[c]) begin errors++; $display("FAIL rstmid_en c%0d got %b exp %b", c, cif.en, oe[c]); end
            if (cif.en && !cons_rej) begin
                e = exp_q.pop_front();
                checks++;
                if (cif.msg !== e) begin errors++; $display("FAIL rstmid_msg c%0d got %h exp %h", c, cif.msg, e); end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_left got %0d exp 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            r_en[i] = 1'b0;
            r_msg[i] = '0;
            cont[i] = 1'b0;
            seq[i] = 0;
        end
        @(negedge clock);
        test_reset();
        test_single();
        test_round_robin();
        test_prio_burst();
        test_reject_hold();
        test_flash();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
